usb2_ep_router: RTL and testbench

Parametrised endpoint router between the USB 2.0 packet engine and NUM_EP endpoint buffers. It replaces the hard-wired per-endpoint select mux with:
- a transaction-scoped latched selection;
- centralised per-endpoint data-toggle and halt (STALL) state;
- a transaction watchdog;
- optional per-endpoint transaction statistics.

It sits between the packet layer and the `usb2_ep0`/`usb2_ep` instances inside the protocol layer.

---
 rtl/usb2_ep_router_if.sv | 45 ++++
 rtl/usb2_ep_router.sv | 214 +++++++++++++++++++++
 tb/tb_usb2_ep_router.sv | 333 +++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/usb2_ep_router_if.sv
// Packet-engine side bus of usb2_ep_router: transaction control, buffer
// read/write port and per-endpoint status returned for the selected endpoint.
interface usb2_ep_router_if #(
   parameter int unsigned ADDR_W = 11,
   parameter int unsigned LEN_W  = 11
);
   logic [3:0]        sel_endp;
   logic              txn_start;
   logic              txn_end;
   logic              txn_abort;
   logic [ADDR_W-1:0] buf_in_addr;
   logic [7:0]        buf_in_data;
   logic              buf_in_wren;
   logic              buf_in_commit;
   logic [LEN_W-1:0]  buf_in_commit_len;
   logic              buf_in_ready;
   logic              buf_in_commit_ack;
   logic [ADDR_W-1:0] buf_out_addr;
   logic              buf_out_arm;
   logic [7:0]        buf_out_q;
   logic [LEN_W-1:0]  buf_out_len;
   logic              buf_out_hasdata;
   logic              buf_out_arm_ack;
   logic [1:0]        endp_mode;
   logic              endp_halted;
   logic              data_toggle_act;
   logic [1:0]        data_toggle;
   logic              setup_rcvd;

   modport master (
      output sel_endp, txn_start, txn_end, buf_in_addr, buf_in_data, buf_in_wren,
             buf_in_commit, buf_in_commit_len, buf_out_addr, buf_out_arm,
             data_toggle_act, setup_rcvd,
      input  txn_abort, buf_in_ready, buf_in_commit_ack, buf_out_q, buf_out_len,
             buf_out_hasdata, buf_out_arm_ack, endp_mode, endp_halted, data_toggle
   );

   modport slave (
      input  sel_endp, txn_start, txn_end, buf_in_addr, buf_in_data, buf_in_wren,
             buf_in_commit, buf_in_commit_len, buf_out_addr, buf_out_arm,
             data_toggle_act, setup_rcvd,
      output txn_abort, buf_in_ready, buf_in_commit_ack, buf_out_q, buf_out_len,
             buf_out_hasdata, buf_out_arm_ack, endp_mode, endp_halted, data_toggle
   );
endinterface

// File: rtl/usb2_ep_router.sv
// USB 2.0 endpoint router: transaction-scoped endpoint select, data toggle/halt
// state, transaction watchdog. Optional statistics via USB2_EP_ROUTER_STATS_EN.
module usb2_ep_router #(
   parameter int unsigned NUM_EP      = 5,
   parameter logic [31:0] EP_MODES    = 32'b10_10_01_10_00,
   parameter int unsigned ADDR_W      = 11,
   parameter int unsigned LEN_W       = 11,
   parameter int unsigned TXN_TIMEOUT = 4096
) (
   input  logic                      phy_clk,
   input  logic                      reset,
   usb2_ep_router_if.slave           io_bus,
   input  logic                      i_halt_set,
   input  logic                      i_halt_clr,
   input  logic [3:0]                i_halt_ep,
   input  logic                      i_toggle_rst_all,
   output logic [NUM_EP*ADDR_W-1:0]  o_ep_buf_in_addr,
   output logic [NUM_EP*8-1:0]       o_ep_buf_in_data,
   output logic [NUM_EP-1:0]         o_ep_buf_in_wren,
   output logic [NUM_EP-1:0]         o_ep_buf_in_commit,
   output logic [NUM_EP*LEN_W-1:0]   o_ep_buf_in_commit_len,
   input  logic [NUM_EP-1:0]         i_ep_buf_in_ready,
   input  logic [NUM_EP-1:0]         i_ep_buf_in_commit_ack,
   output logic [NUM_EP*ADDR_W-1:0]  o_ep_buf_out_addr,
   output logic [NUM_EP-1:0]         o_ep_buf_out_arm,
   input  logic [NUM_EP*8-1:0]       i_ep_buf_out_q,
   input  logic [NUM_EP*LEN_W-1:0]   i_ep_buf_out_len,
   input  logic [NUM_EP-1:0]         i_ep_buf_out_hasdata,
   input  logic [NUM_EP-1:0]         i_ep_buf_out_arm_ack,
   input  logic [3:0]                i_stat_sel,
   output logic [15:0]               o_stat_count
);
   localparam logic [1:0] ModeIsoch = 2'b01;

   typedef enum logic [0:0] {StIdle, StActive} state_e;

   state_e            r_state, w_state_nxt;
   logic [3:0]        r_sel, w_sel_nxt, w_sel;
   logic [15:0]       r_wdog, w_wdog_nxt;
   logic [NUM_EP-1:0] r_tog, w_tog_nxt, r_halt, w_halt_nxt;
   logic              w_active, w_expire, w_abort, w_close, w_strobe_en, w_tog_act;
   logic              w_sel_halt, w_sel_tog;
   logic [1:0]        w_sel_mode;

   assign w_active = (r_state == StActive);
   // Reset forces the view to endpoint 0 so the returned mux is defined.
   assign w_sel    = reset ? 4'd0 : r_sel;
   assign w_expire = w_active && (r_wdog == 16'(TXN_TIMEOUT - 1));
   assign w_close  = w_active && (io_bus.txn_start || io_bus.txn_end);

   always_ff @(posedge phy_clk) begin
      if (reset) begin
         r_state <= StIdle;
         r_sel   <= 4'd0;
         r_wdog  <= 16'd0;
         r_tog   <= '0;
         r_halt  <= '0;
      end else begin
         r_state <= w_state_nxt;
         r_sel   <= w_sel_nxt;
         r_wdog  <= w_wdog_nxt;
         r_tog   <= w_tog_nxt;
         r_halt  <= w_halt_nxt;
      end
   end

   always_comb begin
      w_state_nxt = r_state;
      w_sel_nxt   = r_sel;
      w_wdog_nxt  = r_wdog;
      w_abort     = 1'b0;
      unique case (r_state)
         StIdle: begin
            if (io_bus.txn_start) begin
               w_state_nxt = StActive;
               w_sel_nxt   = io_bus.sel_endp;
               w_wdog_nxt  = 16'd0;
            end
         end
         StActive: begin
            if (io_bus.txn_start) begin
               w_sel_nxt  = io_bus.sel_endp;
               w_wdog_nxt = 16'd0;
            end else if (io_bus.txn_end) begin
               w_state_nxt = StIdle;
            end else if (w_expire) begin
               w_state_nxt = StIdle;
               w_abort     = 1'b1;
            end else begin
               w_wdog_nxt = r_wdog + 16'd1;
            end
         end
         default: w_state_nxt = StIdle;
      endcase
   end

   assign io_bus.txn_abort = w_abort && !reset;

   // Returned mux; an out-of-range selection matches no slice and reads as halted.
   always_comb begin
      w_sel_halt                = 1'b1;
      w_sel_tog                 = 1'b0;
      w_sel_mode                = 2'b00;
      io_bus.buf_in_ready       = 1'b0;
      io_bus.buf_in_commit_ack  = 1'b0;
      io_bus.buf_out_q          = '0;
      io_bus.buf_out_len        = '0;
      io_bus.buf_out_hasdata    = 1'b0;
      io_bus.buf_out_arm_ack    = 1'b0;
      for (int n = 0; n < NUM_EP; n++) begin
         if (w_sel == 4'(n)) begin
            w_sel_halt               = r_halt[n];
            w_sel_tog                = r_tog[n];
            w_sel_mode               = EP_MODES[2*n +: 2];
            io_bus.buf_in_ready      = i_ep_buf_in_ready[n];
            io_bus.buf_in_commit_ack = i_ep_buf_in_commit_ack[n];
            io_bus.buf_out_q         = i_ep_buf_out_q[n*8 +: 8];
            io_bus.buf_out_len       = i_ep_buf_out_len[n*LEN_W +: LEN_W];
            io_bus.buf_out_hasdata   = i_ep_buf_out_hasdata[n];
            io_bus.buf_out_arm_ack   = i_ep_buf_out_arm_ack[n];
         end
      end
   end

   assign io_bus.endp_mode   = w_sel_mode;
   assign io_bus.endp_halted = !reset && w_sel_halt;
   assign io_bus.data_toggle = {1'b0, !reset && w_sel_tog && (w_sel_mode != ModeIsoch)};

   assign w_strobe_en = !reset && w_active && !io_bus.txn_start && !w_sel_halt;

   always_comb begin
      o_ep_buf_in_addr       = '0;
      o_ep_buf_in_data       = '0;
      o_ep_buf_in_wren       = '0;
      o_ep_buf_in_commit     = '0;
      o_ep_buf_in_commit_len = '0;
      o_ep_buf_out_addr      = '0;
      o_ep_buf_out_arm       = '0;
      for (int n = 0; n < NUM_EP; n++) begin
         if (!reset && (w_sel == 4'(n))) begin
            o_ep_buf_in_addr[n*ADDR_W +: ADDR_W]      = io_bus.buf_in_addr;
            o_ep_buf_in_data[n*8 +: 8]                = io_bus.buf_in_data;
            o_ep_buf_in_commit_len[n*LEN_W +: LEN_W]  = io_bus.buf_in_commit_len;
            o_ep_buf_out_addr[n*ADDR_W +: ADDR_W]     = io_bus.buf_out_addr;
            o_ep_buf_in_wren[n]   = w_strobe_en && io_bus.buf_in_wren;
            o_ep_buf_in_commit[n] = w_strobe_en && io_bus.buf_in_commit;
            o_ep_buf_out_arm[n]   = w_strobe_en && io_bus.buf_out_arm;
         end
      end
   end

   assign w_tog_act = w_active && io_bus.data_toggle_act && !w_sel_halt &&
                      (w_sel_mode != ModeIsoch);

   // Later assignments win: act, then setup, then clear, then set, then global reset.
   always_comb begin
      w_tog_nxt  = r_tog;
      w_halt_nxt = r_halt;
      for (int n = 0; n < NUM_EP; n++) begin
         if (w_tog_act && (w_sel == 4'(n))) w_tog_nxt[n] = ~r_tog[n];
      end
      if (io_bus.setup_rcvd) begin
         w_tog_nxt[0]  = 1'b1;
         w_halt_nxt[0] = 1'b0;
      end
      for (int n = 0; n < NUM_EP; n++) begin
         if (i_halt_ep == 4'(n)) begin
            if (i_halt_clr && !i_halt_set) begin
               w_halt_nxt[n] = 1'b0;
               w_tog_nxt[n]  = 1'b0;
            end
            if (i_halt_set) w_halt_nxt[n] = 1'b1;
         end
      end
      if (i_toggle_rst_all) begin
         w_tog_nxt  = '0;
         w_halt_nxt = '0;
      end
   end

`ifdef USB2_EP_ROUTER_STATS_EN
   logic [15:0] r_stat_cnt [NUM_EP];
   logic [15:0] r_stat_out;

   always_ff @(posedge phy_clk) begin
      if (reset || i_toggle_rst_all) begin
         for (int n = 0; n < NUM_EP; n++) r_stat_cnt[n] <= 16'd0;
      end else if (w_close) begin
         for (int n = 0; n < NUM_EP; n++) begin
            if ((r_sel == 4'(n)) && (r_stat_cnt[n] != 16'hFFFF)) begin
               r_stat_cnt[n] <= r_stat_cnt[n] + 16'd1;
            end
         end
      end
   end

   always_ff @(posedge phy_clk) begin
      if (reset) begin
         r_stat_out <= 16'd0;
      end else begin
         r_stat_out <= 16'd0;
         for (int n = 0; n < NUM_EP; n++) begin
            if (i_stat_sel == 4'(n)) r_stat_out <= r_stat_cnt[n];
         end
      end
   end

   assign o_stat_count = r_stat_out;
`else
   logic w_unused_stat;
   assign w_unused_stat = ^{i_stat_sel, w_close};
   assign o_stat_count  = 16'd0;
`endif
endmodule

// File: tb/tb_usb2_ep_router.sv
// Self-checking bench for usb2_ep_router: vector table for toggle/halt/select
// behaviour plus directed sequences for forwarding, watchdog, reset and stats.
module tb_usb2_ep_router;
   localparam int unsigned NUM_EP = 5;
   localparam int unsigned ADDR_W = 11;
   localparam int unsigned LEN_W  = 11;
   localparam int unsigned TMO    = 16;

   logic phy_clk = 1'b0;
   logic reset;
   always #5 phy_clk = ~phy_clk;

   logic                     halt_set, halt_clr, toggle_rst_all;
   logic [3:0]               halt_ep, stat_sel;
   logic [15:0]              stat_count;
   logic [NUM_EP*ADDR_W-1:0] ep_buf_in_addr, ep_buf_out_addr;
   logic [NUM_EP*8-1:0]      ep_buf_in_data, ep_buf_out_q;
   logic [NUM_EP*LEN_W-1:0]  ep_buf_in_commit_len, ep_buf_out_len;
   logic [NUM_EP-1:0]        ep_buf_in_wren, ep_buf_in_commit, ep_buf_out_arm;
   logic [NUM_EP-1:0]        ep_buf_in_ready, ep_buf_in_commit_ack;
   logic [NUM_EP-1:0]        ep_buf_out_hasdata, ep_buf_out_arm_ack;

   usb2_ep_router_if #(.ADDR_W(ADDR_W), .LEN_W(LEN_W)) u_bus ();

   usb2_ep_router #(
      .NUM_EP      (NUM_EP),
      .ADDR_W      (ADDR_W),
      .LEN_W       (LEN_W),
      .TXN_TIMEOUT (TMO)
   ) dut (
      .phy_clk                (phy_clk),
      .reset                  (reset),
      .io_bus                 (u_bus),
      .i_halt_set             (halt_set),
      .i_halt_clr             (halt_clr),
      .i_halt_ep              (halt_ep),
      .i_toggle_rst_all       (toggle_rst_all),
      .o_ep_buf_in_addr       (ep_buf_in_addr),
      .o_ep_buf_in_data       (ep_buf_in_data),
      .o_ep_buf_in_wren       (ep_buf_in_wren),
      .o_ep_buf_in_commit     (ep_buf_in_commit),
      .o_ep_buf_in_commit_len (ep_buf_in_commit_len),
      .i_ep_buf_in_ready      (ep_buf_in_ready),
      .i_ep_buf_in_commit_ack (ep_buf_in_commit_ack),
      .o_ep_buf_out_addr      (ep_buf_out_addr),
      .o_ep_buf_out_arm       (ep_buf_out_arm),
      .i_ep_buf_out_q         (ep_buf_out_q),
      .i_ep_buf_out_len       (ep_buf_out_len),
      .i_ep_buf_out_hasdata   (ep_buf_out_hasdata),
      .i_ep_buf_out_arm_ack   (ep_buf_out_arm_ack),
      .i_stat_sel             (stat_sel),
      .o_stat_count           (stat_count)
   );

   int checks   = 0;
   int failures = 0;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge phy_clk);
      #1;
   endtask

   task automatic clear_pulses();
      u_bus.txn_start       = 1'b0;
      u_bus.txn_end         = 1'b0;
      u_bus.buf_in_wren     = 1'b0;
      u_bus.buf_in_commit   = 1'b0;
      u_bus.buf_out_arm     = 1'b0;
      u_bus.data_toggle_act = 1'b0;
      u_bus.setup_rcvd      = 1'b0;
      halt_set              = 1'b0;
      halt_clr              = 1'b0;
      toggle_rst_all        = 1'b0;
   endtask

   typedef struct {
      logic       start;
      logic [3:0] sel;
      logic       tend;
      logic       act;
      logic       setup;
      logic       hset;
      logic       hclr;
      logic [3:0] hep;
      logic       trst;
      logic [1:0] e_tog;
      logic       e_halt;
      logic [1:0] e_mode;
   } vec_t;

   vec_t vecs[$];

   function automatic void add(input logic st, input logic [3:0] sel, input logic en,
                               input logic act, input logic su, input logic hs,
                               input logic hc, input logic [3:0] hep, input logic tr,
                               input logic [1:0] tog, input logic halt,
                               input logic [1:0] mode);
      vec_t v;
      v = '{st, sel, en, act, su, hs, hc, hep, tr, tog, halt, mode};
      vecs.push_back(v);
   endfunction

   int cyc;

   initial begin
      // Modes: ep0 ctrl, ep1 bulk, ep2 isoch, ep3 bulk, ep4 bulk.
      //  st sel en act su hs hc hep tr | tog halt mode
      add(1, 1, 0, 0, 0, 0, 0, 0, 0,   2'b00, 0, 2'd2);
      add(0, 0, 0, 1, 0, 0, 0, 0, 0,   2'b01, 0, 2'd2);
      add(0, 0, 0, 1, 0, 0, 0, 0, 0,   2'b00, 0, 2'd2);
      add(0, 0, 0, 1, 0, 0, 0, 0, 0,   2'b01, 0, 2'd2);
      add(0, 0, 0, 0, 0, 0, 1, 1, 0,   2'b00, 0, 2'd2);
      add(0, 0, 0, 1, 0, 0, 0, 0, 0,   2'b01, 0, 2'd2);
      add(0, 0, 0, 0, 0, 1, 0, 1, 0,   2'b01, 1, 2'd2);
      add(0, 0, 0, 1, 0, 0, 0, 0, 0,   2'b01, 1, 2'd2);
      add(0, 0, 0, 0, 0, 0, 1, 1, 0,   2'b00, 0, 2'd2);
      add(1, 2, 0, 0, 0, 0, 0, 0, 0,   2'b00, 0, 2'd1);
      add(0, 0, 0, 1, 0, 0, 0, 0, 0,   2'b00, 0, 2'd1);
      add(0, 0, 0, 1, 0, 0, 0, 0, 0,   2'b00, 0, 2'd1);
      add(0, 0, 0, 0, 0, 1, 1, 2, 0,   2'b00, 1, 2'd1);
      add(0, 0, 1, 0, 0, 0, 0, 0, 0,   2'b00, 1, 2'd1);
      add(1, 0, 0, 0, 0, 0, 0, 0, 0,   2'b00, 0, 2'd0);
      add(0, 0, 0, 1, 0, 0, 0, 0, 0,   2'b01, 0, 2'd0);
      add(0, 0, 0, 1, 0, 0, 0, 0, 0,   2'b00, 0, 2'd0);
      add(0, 0, 0, 0, 0, 1, 0, 0, 0,   2'b00, 1, 2'd0);
      add(0, 0, 0, 0, 1, 0, 0, 0, 0,   2'b01, 0, 2'd0);
      add(0, 0, 0, 0, 0, 1, 0, 9, 0,   2'b01, 0, 2'd0);
      add(0, 0, 0, 0, 1, 1, 0, 0, 1,   2'b00, 0, 2'd0);
      add(1, 2, 0, 0, 0, 0, 0, 0, 0,   2'b00, 0, 2'd1);
      add(1, 7, 0, 0, 0, 0, 0, 0, 0,   2'b00, 1, 2'd0);
      add(0, 0, 0, 1, 0, 1, 0, 3, 0,   2'b00, 1, 2'd0);
      add(1, 3, 0, 0, 0, 0, 0, 0, 0,   2'b00, 1, 2'd2);
      add(0, 0, 0, 1, 0, 0, 1, 3, 0,   2'b00, 0, 2'd2);
      add(0, 0, 0, 1, 0, 0, 0, 0, 0,   2'b01, 0, 2'd2);
      add(0, 0, 1, 0, 0, 0, 0, 0, 0,   2'b01, 0, 2'd2);
      add(0, 0, 0, 1, 0, 0, 0, 0, 0,   2'b01, 0, 2'd2);

      clear_pulses();
      u_bus.sel_endp          = 4'd2;
      u_bus.buf_in_addr       = 11'd3;
      u_bus.buf_in_data       = 8'h5A;
      u_bus.buf_in_commit_len = 11'd0;
      u_bus.buf_out_addr      = 11'd9;
      halt_ep                 = 4'd0;
      stat_sel                = 4'd1;
      ep_buf_in_ready         = '0;
      ep_buf_in_commit_ack    = '0;
      ep_buf_out_q            = 40'h55_44_33_22_11;
      ep_buf_out_len          = '0;
      ep_buf_out_hasdata      = '0;
      ep_buf_out_arm_ack      = '0;

      // Strobes and a start held during reset must have no effect.
      reset                = 1'b1;
      u_bus.txn_start      = 1'b1;
      u_bus.buf_in_wren    = 1'b1;
      u_bus.buf_out_arm    = 1'b1;
      tick();
      tick();
      chk("rst_abort", 64'(u_bus.txn_abort), 64'd0);
      chk("rst_halted", 64'(u_bus.endp_halted), 64'd0);
      chk("rst_mode", 64'(u_bus.endp_mode), 64'd0);
      chk("rst_toggle", 64'(u_bus.data_toggle), 64'd0);
      chk("rst_stat", 64'(stat_count), 64'd0);
      chk("rst_ep_addr", 64'(ep_buf_in_addr), 64'd0);
      chk("rst_ep_data", 64'(ep_buf_in_data), 64'd0);
      chk("rst_ep_wren", 64'(ep_buf_in_wren), 64'd0);
      chk("rst_ep_arm", 64'(ep_buf_out_arm), 64'd0);
      chk("rst_ep_out_addr", 64'(ep_buf_out_addr), 64'd0);
      chk("rst_out_q_ep0", 64'(u_bus.buf_out_q), 64'h11);
      clear_pulses();
      reset = 1'b0;
      tick();
      chk("idle_out_q_ep0", 64'(u_bus.buf_out_q), 64'h11);
      chk("idle_no_wren", 64'(ep_buf_in_wren), 64'd0);

      foreach (vecs[i]) begin
         u_bus.txn_start       = vecs[i].start;
         u_bus.sel_endp        = vecs[i].sel;
         u_bus.txn_end         = vecs[i].tend;
         u_bus.data_toggle_act = vecs[i].act;
         u_bus.setup_rcvd      = vecs[i].setup;
         halt_set              = vecs[i].hset;
         halt_clr              = vecs[i].hclr;
         halt_ep               = vecs[i].hep;
         toggle_rst_all        = vecs[i].trst;
         tick();
         clear_pulses();
         #1;
         chk($sformatf("vec%0d_toggle", i), 64'(u_bus.data_toggle), 64'(vecs[i].e_tog));
         chk($sformatf("vec%0d_halted", i), 64'(u_bus.endp_halted), 64'(vecs[i].e_halt));
         chk($sformatf("vec%0d_mode", i), 64'(u_bus.endp_mode), 64'(vecs[i].e_mode));
      end

      // Write and commit routed to endpoint 2 only; write coincident with start dropped.
      u_bus.sel_endp    = 4'd2;
      u_bus.txn_start   = 1'b1;
      u_bus.buf_in_wren = 1'b1;
      u_bus.buf_in_addr = 11'd5;
      u_bus.buf_in_data = 8'hA5;
      #1;
      chk("wren_at_start_dropped", 64'(ep_buf_in_wren), 64'd0);
      tick();
      u_bus.txn_start = 1'b0;
      #1;
      chk("fwd_wren", 64'(ep_buf_in_wren), 64'b00100);
      chk("fwd_addr", 64'(ep_buf_in_addr), 64'd5 << 22);
      chk("fwd_data", 64'(ep_buf_in_data), 64'hA5 << 16);
      u_bus.buf_in_wren       = 1'b0;
      u_bus.buf_in_commit     = 1'b1;
      u_bus.buf_in_commit_len = 11'd64;
      ep_buf_in_commit_ack    = 5'b00100;
      #1;
      chk("fwd_commit", 64'(ep_buf_in_commit), 64'b00100);
      chk("fwd_commit_len", 64'(ep_buf_in_commit_len), 64'd64 << 22);
      chk("ret_commit_ack", 64'(u_bus.buf_in_commit_ack), 64'd1);
      tick();
      u_bus.buf_in_commit = 1'b0;
      ep_buf_in_commit_ack = '0;
      u_bus.txn_end = 1'b1;
      tick();
      u_bus.txn_end = 1'b0;
      u_bus.buf_in_commit = 1'b1;
      #1;
      chk("idle_commit_blocked", 64'(ep_buf_in_commit), 64'd0);
      u_bus.buf_in_commit = 1'b0;

      // Invalid endpoint: halted, returned data zero, no arm forwarded.
      u_bus.sel_endp  = 4'd7;
      u_bus.txn_start = 1'b1;
      tick();
      u_bus.txn_start   = 1'b0;
      u_bus.buf_out_arm = 1'b1;
      #1;
      chk("inv_halted", 64'(u_bus.endp_halted), 64'd1);
      chk("inv_out_q", 64'(u_bus.buf_out_q), 64'd0);
      chk("inv_arm", 64'(ep_buf_out_arm), 64'd0);
      chk("inv_out_addr", 64'(ep_buf_out_addr), 64'd0);
      u_bus.buf_out_arm = 1'b0;
      u_bus.txn_end = 1'b1;
      tick();
      u_bus.txn_end = 1'b0;

      // Watchdog: abort 16 cycles after the txn_start cycle, one cycle wide.
      u_bus.sel_endp  = 4'd1;
      u_bus.txn_start = 1'b1;
      tick();
      u_bus.txn_start = 1'b0;
      #1;
      cyc = 0;
      while (!u_bus.txn_abort && cyc < 40) begin
         tick();
         cyc++;
      end
      chk("wdog_latency", 64'(cyc), 64'(TMO - 1));
      tick();
      chk("wdog_pulse_width", 64'(u_bus.txn_abort), 64'd0);
      u_bus.buf_in_wren = 1'b1;
      #1;
      chk("wdog_idle_after", 64'(ep_buf_in_wren), 64'd0);
      u_bus.buf_in_wren = 1'b0;

      // Reset while the abort would be showing: no abort, back to IDLE.
      u_bus.txn_start = 1'b1;
      tick();
      u_bus.txn_start = 1'b0;
      repeat (TMO - 1) tick();
      chk("pre_rst_abort_visible", 64'(u_bus.txn_abort), 64'd1);
      reset = 1'b1;
      #1;
      chk("rst_mid_abort", 64'(u_bus.txn_abort), 64'd0);
      tick();
      reset = 1'b0;
      u_bus.buf_in_wren = 1'b1;
      #1;
      chk("rst_mid_idle", 64'(ep_buf_in_wren), 64'd0);
      chk("rst_mid_abort_after", 64'(u_bus.txn_abort), 64'd0);
      u_bus.buf_in_wren = 1'b0;

`ifdef USB2_EP_ROUTER_STATS_EN
      u_bus.sel_endp = 4'd4;
      stat_sel       = 4'd4;
      repeat (3) begin
         u_bus.txn_start = 1'b1;
         tick();
         u_bus.txn_start = 1'b0;
         u_bus.txn_end   = 1'b1;
         tick();
         u_bus.txn_end   = 1'b0;
      end
      u_bus.txn_start = 1'b1;
      tick();
      u_bus.txn_start = 1'b0;
      repeat (TMO + 2) tick();
      chk("stat_three_abort_not_counted", 64'(stat_count), 64'd3);
      u_bus.txn_start = 1'b1;
      repeat (70000) tick();
      u_bus.txn_start = 1'b0;
      u_bus.txn_end   = 1'b1;
      tick();
      u_bus.txn_end   = 1'b0;
      tick();
      tick();
      chk("stat_saturate", 64'(stat_count), 64'hFFFF);
      toggle_rst_all = 1'b1;
      tick();
      toggle_rst_all = 1'b0;
      tick();
      chk("stat_rst_all", 64'(stat_count), 64'd0);
`else
      u_bus.sel_endp  = 4'd1;
      u_bus.txn_start = 1'b1;
      tick();
      u_bus.txn_start = 1'b0;
      u_bus.txn_end   = 1'b1;
      tick();
      u_bus.txn_end   = 1'b0;
      tick();
      chk("stat_tied_zero", 64'(stat_count), 64'd0);
`endif

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
